spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 198 +++++++++++++++++++
 tb/tb_spi_slave.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave with synchronized sclk/cs_n/mosi sampled by the system clock.
// Supports all four SPI modes, back-to-back words, one-word tx holding register.
module spi_slave #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             tx_underrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t           state_r, state_next_s;
    logic [1:0]       cs_sync_r, sclk_sync_r, mosi_sync_r, sync_ok_r;
    logic             cs_d_r, sclk_d_r, armed_r;
    logic             cpol_r, cpha_r, fresh_r;
    logic [CW-1:0]    bit_cnt_r;
    logic [WIDTH-1:0] hold_r, tx_sh_r, rx_sh_r, rx_data_r;
    logic             tx_ready_r, miso_r, miso_oe_r, rx_valid_r, busy_r;
    logic             frame_err_r, tx_underrun_r;

    logic             cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
    logic             frame_start_s, frame_end_s, lead_s, trail_s;
    logic             capture_s, shift_s, reload_s, load_s, write_s;
    logic [WIDTH-1:0] word_s, rx_word_s;

    assign cs_fall_s   = cs_d_r & ~cs_sync_r[1];
    assign cs_rise_s   = ~cs_d_r & cs_sync_r[1];
    assign sclk_rise_s = ~sclk_d_r & sclk_sync_r[1];
    assign sclk_fall_s = sclk_d_r & ~sclk_sync_r[1];

    // Synchronizers, edge-detect delay taps and the frame-start arming flag.
    // armed_r only sets once the synchronizer holds a real pin sample of cs_n high,
    // so a cs_n already low when reset is released cannot start a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_r   <= 2'b11;
            sclk_sync_r <= 2'b00;
            mosi_sync_r <= 2'b00;
            sync_ok_r   <= 2'b00;
            cs_d_r      <= 1'b1;
            sclk_d_r    <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[0], cs_n};
            sclk_sync_r <= {sclk_sync_r[0], sclk};
            mosi_sync_r <= {mosi_sync_r[0], mosi};
            sync_ok_r   <= {sync_ok_r[0], 1'b1};
            cs_d_r      <= cs_sync_r[1];
            sclk_d_r    <= sclk_sync_r[1];
            armed_r     <= armed_r | (sync_ok_r[1] & cs_sync_r[1]);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and frame/sclk-edge strobes.
    always_comb begin
        state_next_s  = state_r;
        frame_start_s = 1'b0;
        frame_end_s   = 1'b0;
        lead_s        = 1'b0;
        trail_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (cs_fall_s && armed_r) begin
                    state_next_s  = ACTIVE;
                    frame_start_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_rise_s) begin
                    state_next_s = IDLE;
                    frame_end_s  = 1'b1;
                end else begin
                    lead_s  = cpol_r ? sclk_fall_s : sclk_rise_s;
                    trail_s = cpol_r ? sclk_rise_s : sclk_fall_s;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Between words a shift edge at bit count 0 is a reload; fresh_r marks the
    // CPHA=1 case where the frame-start load has not yet been presented.
    assign capture_s = cpha_r ? trail_s : lead_s;
    assign shift_s   = cpha_r ? lead_s : trail_s;
    assign reload_s  = shift_s & (bit_cnt_r == {CW{1'b0}}) & ~fresh_r;
    assign load_s    = frame_start_s | reload_s;
    assign write_s   = tx_valid & tx_ready_r;
    assign word_s    = tx_ready_r ? {WIDTH{1'b0}} : hold_r;
    assign rx_word_s = {rx_sh_r[WIDTH-2:0], mosi_sync_r[1]};

    // Datapath: holding register, tx/rx shift registers, bit counter, pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol_r        <= 1'b0;
            cpha_r        <= 1'b0;
            fresh_r       <= 1'b0;
            bit_cnt_r     <= {CW{1'b0}};
            hold_r        <= {WIDTH{1'b0}};
            tx_sh_r       <= {WIDTH{1'b0}};
            rx_sh_r       <= {WIDTH{1'b0}};
            rx_data_r     <= {WIDTH{1'b0}};
            tx_ready_r    <= 1'b1;
            miso_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
            rx_valid_r    <= 1'b0;
            busy_r        <= 1'b0;
            frame_err_r   <= 1'b0;
            tx_underrun_r <= 1'b0;
        end else begin
            miso_oe_r     <= ~cs_sync_r[0];
            busy_r        <= (state_next_s == ACTIVE);
            rx_valid_r    <= 1'b0;
            frame_err_r   <= frame_end_s & (bit_cnt_r != {CW{1'b0}});
            tx_underrun_r <= load_s & tx_ready_r;

            if (write_s) begin
                hold_r     <= tx_data;
                tx_ready_r <= 1'b0;
            end else if (load_s) begin
                tx_ready_r <= 1'b1;
            end else begin
                tx_ready_r <= tx_ready_r;
            end

            if (frame_start_s) begin
                cpol_r    <= mode[1];
                cpha_r    <= mode[0];
                bit_cnt_r <= {CW{1'b0}};
                fresh_r   <= 1'b1;
                if (mode[0]) begin
                    tx_sh_r <= word_s;
                end else begin
                    miso_r  <= word_s[WIDTH-1];
                    tx_sh_r <= {word_s[WIDTH-2:0], 1'b0};
                end
            end else if (shift_s) begin
                fresh_r <= 1'b0;
                if (reload_s) begin
                    miso_r  <= word_s[WIDTH-1];
                    tx_sh_r <= {word_s[WIDTH-2:0], 1'b0};
                end else begin
                    miso_r  <= tx_sh_r[WIDTH-1];
                    tx_sh_r <= {tx_sh_r[WIDTH-2:0], 1'b0};
                end
            end else if (capture_s) begin
                if (bit_cnt_r == CW'(WIDTH - 1)) begin
                    rx_data_r  <= rx_word_s;
                    rx_valid_r <= 1'b1;
                    bit_cnt_r  <= {CW{1'b0}};
                end else begin
                    rx_sh_r   <= rx_word_s;
                    bit_cnt_r <= bit_cnt_r + CW'(1);
                end
            end else begin
                fresh_r <= fresh_r;
            end
        end
    end

    assign miso        = miso_r;
    assign miso_oe     = miso_oe_r;
    assign tx_ready    = tx_ready_r;
    assign rx_data     = rx_data_r;
    assign rx_valid    = rx_valid_r;
    assign busy        = busy_r;
    assign frame_err   = frame_err_r;
    assign tx_underrun = tx_underrun_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives frames in each mode
// and compares miso words, received words and status pulses against hand values.
module tb_spi_slave;

    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, busy, frame_err, tx_underrun;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_errors = 0;
    int rxv_cnt  = 0;
    int ferr_cnt = 0;
    int und_cnt  = 0;
    logic [7:0] rx_seen [0:3];
    logic [7:0] mi1, mi2;

    spi_slave #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err),
        .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    // Pulse monitors sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rxv_cnt < 4) rx_seen[rxv_cnt] = rx_data;
            rxv_cnt = rxv_cnt + 1;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (tx_underrun) und_cnt = und_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rxv_cnt  = 0;
        ferr_cnt = 0;
        und_cnt  = 0;
    endtask

    task automatic tx_write(input logic [7:0] d);
        int k;
        k = 0;
        @(negedge clk);
        while (!tx_ready && k < 200) begin
            @(negedge clk);
            k = k + 1;
        end
        if (!tx_ready) begin
            check_val("tx_ready_wait", 32'(tx_ready), 32'd1);
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic idle_mode(input logic [1:0] m);
        mode = m;
        sclk = m[1];
        #(HALF * 4);
    endtask

    task automatic frame_begin();
        @(negedge clk);
        cs_n = 1'b0;
        #(HALF * 2);
    endtask

    task automatic frame_end();
        #HALF;
        cs_n = 1'b1;
        #(HALF * 4);
    endtask

    // Master side: n bits MSB first; returns the bits it sampled from miso.
    task automatic xfer(input logic [1:0] m, input logic [7:0] mo, input int n,
                        output logic [7:0] mi);
        mi = 8'h00;
        for (int k = 0; k < n; k++) begin
            if (!m[0]) begin
                mosi = mo[7-k];
                #HALF;
                sclk = ~m[1];
                mi[7-k] = miso;
                #HALF;
                sclk = m[1];
            end else begin
                sclk = ~m[1];
                mosi = mo[7-k];
                #HALF;
                sclk = m[1];
                mi[7-k] = miso;
                #HALF;
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] mtab [0:2];
        mtab[0] = 2'd1; mtab[1] = 2'd2; mtab[2] = 2'd3;

        // Reset values
        repeat (4) @(negedge clk);
        check_val("rst_miso", 32'(miso), 32'd0);
        check_val("rst_miso_oe", 32'(miso_oe), 32'd0);
        check_val("rst_rx_data", 32'(rx_data), 32'h0);
        check_val("rst_tx_ready", 32'(tx_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_pulses", {29'd0, rx_valid, frame_err, tx_underrun}, 32'd0);
        rst_n = 1'b1;
        #(HALF * 4);

        // Mode 0 single word
        clear_mon();
        idle_mode(2'd0);
        tx_write(8'hA5);
        check_val("m0_tx_ready_full", 32'(tx_ready), 32'd0);
        frame_begin();
        check_val("m0_busy", 32'(busy), 32'd1);
        check_val("m0_miso_oe", 32'(miso_oe), 32'd1);
        check_val("m0_tx_ready_after_load", 32'(tx_ready), 32'd1);
        check_val("m0_no_underrun_at_start", 32'(und_cnt), 32'd0);
        xfer(2'd0, 8'h3C, 8, mi1);
        frame_end();
        check_val("m0_miso_word", 32'(mi1), 32'hA5);
        check_val("m0_rx_data", 32'(rx_data), 32'h3C);
        check_val("m0_rx_valid_count", 32'(rxv_cnt), 32'd1);
        check_val("m0_frame_err", 32'(ferr_cnt), 32'd0);
        check_val("m0_busy_end", 32'(busy), 32'd0);
        check_val("m0_miso_oe_end", 32'(miso_oe), 32'd0);

        // Modes 1..3
        for (int i = 0; i < 3; i++) begin
            clear_mon();
            idle_mode(mtab[i]);
            tx_write(8'h81);
            frame_begin();
            xfer(mtab[i], 8'h7E, 8, mi1);
            frame_end();
            check_val($sformatf("mode%0d_miso", mtab[i]), 32'(mi1), 32'h81);
            check_val($sformatf("mode%0d_rx", mtab[i]), 32'(rx_data), 32'h7E);
            check_val($sformatf("mode%0d_rxv", mtab[i]), 32'(rxv_cnt), 32'd1);
        end

        // Back-to-back words, mode 0, second word written after first load
        clear_mon();
        idle_mode(2'd0);
        tx_write(8'h11);
        frame_begin();
        fork
            begin
                xfer(2'd0, 8'hF0, 8, mi1);
                xfer(2'd0, 8'h0F, 8, mi2);
            end
            begin
                #(HALF * 4);
                tx_write(8'h22);
            end
        join
        frame_end();
        check_val("b2b_miso1", 32'(mi1), 32'h11);
        check_val("b2b_miso2", 32'(mi2), 32'h22);
        check_val("b2b_rxv", 32'(rxv_cnt), 32'd2);
        check_val("b2b_rx1", 32'(rx_seen[0]), 32'hF0);
        check_val("b2b_rx2", 32'(rx_seen[1]), 32'h0F);
        check_val("b2b_frame_err", 32'(ferr_cnt), 32'd0);

        // Underrun at frame start, mode 3
        clear_mon();
        idle_mode(2'd3);
        frame_begin();
        check_val("und_at_start", 32'(und_cnt), 32'd1);
        xfer(2'd3, 8'h96, 8, mi1);
        frame_end();
        check_val("und_miso_zero", 32'(mi1), 32'h00);
        check_val("und_rx", 32'(rx_data), 32'h96);

        // Abort after 5 bits
        clear_mon();
        idle_mode(2'd0);
        frame_begin();
        xfer(2'd0, 8'hFF, 5, mi1);
        frame_end();
        check_val("abort_frame_err", 32'(ferr_cnt), 32'd1);
        check_val("abort_rx_unchanged", 32'(rx_data), 32'h96);
        check_val("abort_rxv", 32'(rxv_cnt), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);

        // Reset mid-frame with cs_n held low
        clear_mon();
        frame_begin();
        xfer(2'd0, 8'hFF, 3, mi1);
        @(negedge clk);
        rst_n = 1'b0;
        #(HALF);
        rst_n = 1'b1;
        #(HALF * 2);
        check_val("rstmid_busy", 32'(busy), 32'd0);
        xfer(2'd0, 8'hFF, 8, mi1);
        #(HALF * 2);
        check_val("rstmid_rxv", 32'(rxv_cnt), 32'd0);
        check_val("rstmid_rx_data", 32'(rx_data), 32'h0);
        check_val("rstmid_busy_after", 32'(busy), 32'd0);
        check_val("rstmid_frame_err", 32'(ferr_cnt), 32'd0);
        cs_n = 1'b1;
        #(HALF * 4);
        tx_write(8'h5A);
        frame_begin();
        check_val("rstmid_new_busy", 32'(busy), 32'd1);
        xfer(2'd0, 8'hC3, 8, mi1);
        frame_end();
        check_val("rstmid_new_miso", 32'(mi1), 32'h5A);
        check_val("rstmid_new_rx", 32'(rx_data), 32'hC3);
        check_val("rstmid_new_rxv", 32'(rxv_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
